inst_queue: RTL and testbench

//  Instruction queue between fetch (IF) and decode (ID) in the dual-issue pipeline.

---
 rtl/inst_queue_pkg.sv | 17 +
 rtl/inst_queue_ram.sv | 32 +++
 rtl/inst_queue.sv | 87 ++++++++
 tb/tb_inst_queue.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/inst_queue_pkg.sv
// Shared constants, entry type and helpers for the IF->ID instruction queue.
package inst_queue_pkg;

    localparam int IQ_DEPTH     = 16;
    localparam int IQ_ENTRY_WD  = 64;
    localparam int FETCH_BUS_WD = 1 + 2 + 32 + 64;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } iq_entry_t;

    function automatic logic [1:0] mask_count(input logic [1:0] mask);
        return {1'b0, mask[0]} + {1'b0, mask[1]};
    endfunction

endpackage

// File: rtl/inst_queue_ram.sv
// Entry storage for the instruction queue: two write ports, two asynchronous read ports.
module inst_queue_ram
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we0,
    input  logic [PTR_W-1:0] waddr0,
    input  iq_entry_t        wdata0,
    input  logic             we1,
    input  logic [PTR_W-1:0] waddr1,
    input  iq_entry_t        wdata1,
    input  logic [PTR_W-1:0] raddr0,
    input  logic [PTR_W-1:0] raddr1,
    output iq_entry_t        rdata0,
    output iq_entry_t        rdata1
);

    iq_entry_t mem [DEPTH];

    // The top guarantees waddr0 != waddr1 whenever both enables are high.
    always_ff @(posedge clk) begin
        if (we0) mem[waddr0] <= wdata0;
        if (we1) mem[waddr1] <= wdata1;
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: packs valid fetch slots into a circular
// FIFO and presents the two oldest entries to ID.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        fetch_valid,
    input  logic [1:0]  fetch_mask,
    input  logic [31:0] fetch_pc,
    input  logic [63:0] fetch_inst,
    output logic        iq_stall,
    output logic        out_valid1,
    output logic [31:0] out_pc1,
    output logic [31:0] out_inst1,
    output logic        out_valid2,
    output logic [31:0] out_pc2,
    output logic [31:0] out_inst2,
    input  logic [1:0]  id_pop
);

    localparam logic [PTR_W:0] DEPTH_C   = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] STALL_TH  = (PTR_W+1)'(DEPTH - 2);
    localparam logic [PTR_W:0] TWO_C     = (PTR_W+1)'(2);

    logic [PTR_W-1:0] head, tail;
    logic [PTR_W:0]   count;

    logic [PTR_W:0]   free_cnt;
    logic [1:0]       req_push, npush, npop;
    iq_entry_t        entry_a, entry_b, rd1, rd2;

    assign free_cnt = DEPTH_C - count;
    assign req_push = fetch_valid ? mask_count(fetch_mask) : 2'd0;

    // Slots beyond the free space are dropped so the pointers can never overrun.
    always_comb begin
        npush = req_push;
        if ({{(PTR_W-1){1'b0}}, req_push} > free_cnt) npush = free_cnt[1:0];
        npop = id_pop;
        if ({{(PTR_W-1){1'b0}}, id_pop} > count) npop = count[1:0];
    end

    // A lone upper slot is packed down to the tail position.
    assign entry_a = fetch_mask[0] ? '{pc: fetch_pc, inst: fetch_inst[31:0]}
                                   : '{pc: fetch_pc + 32'd4, inst: fetch_inst[63:32]};
    assign entry_b = '{pc: fetch_pc + 32'd4, inst: fetch_inst[63:32]};

    inst_queue_ram #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ram (
        .clk    (clk),
        .we0    (~flush & (npush != 2'd0)),
        .waddr0 (tail),
        .wdata0 (entry_a),
        .we1    (~flush & (npush == 2'd2)),
        .waddr1 (tail + PTR_W'(1)),
        .wdata1 (entry_b),
        .raddr0 (head),
        .raddr1 (head + PTR_W'(1)),
        .rdata0 (rd1),
        .rdata1 (rd2)
    );

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            tail  <= tail + PTR_W'(npush);
            head  <= head + PTR_W'(npop);
            count <= count + (PTR_W+1)'(npush) - (PTR_W+1)'(npop);
        end
    end

    assign iq_stall   = count > STALL_TH;
    assign out_valid1 = (count != '0) & ~flush;
    assign out_valid2 = (count >= TWO_C) & ~flush;
    assign out_pc1    = rd1.pc;
    assign out_inst1  = rd1.inst;
    assign out_pc2    = rd2.pc;
    assign out_inst2  = rd2.inst;

endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue (DEPTH=16).
module tb_inst_queue;

    logic        clk = 1'b0;
    logic        resetn, flush, fetch_valid;
    logic [1:0]  fetch_mask, id_pop;
    logic [31:0] fetch_pc;
    logic [63:0] fetch_inst;
    logic        iq_stall, out_valid1, out_valid2;
    logic [31:0] out_pc1, out_inst1, out_pc2, out_inst2;

    int total_checks = 0;
    int pass_checks  = 0;
    logic [31:0] exp_q [14];

    inst_queue dut (
        .clk(clk), .resetn(resetn), .flush(flush), .fetch_valid(fetch_valid),
        .fetch_mask(fetch_mask), .fetch_pc(fetch_pc), .fetch_inst(fetch_inst),
        .iq_stall(iq_stall), .out_valid1(out_valid1), .out_pc1(out_pc1),
        .out_inst1(out_inst1), .out_valid2(out_valid2), .out_pc2(out_pc2),
        .out_inst2(out_inst2), .id_pop(id_pop)
    );

    always #5 clk = ~clk;

    // Instruction words are derived from their address so ordering errors show up in inst too.
    task automatic applyStimulus(input logic fv, input logic [1:0] m, input logic [31:0] pc,
                                 input logic [1:0] pop, input logic fl);
        fetch_valid = fv;
        fetch_mask  = m;
        fetch_pc    = pc;
        fetch_inst  = {~(pc + 32'd4), ~pc};
        id_pop      = pop;
        flush       = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [1:0] m, input logic [31:0] pc, input logic [1:0] pop);
        applyStimulus(1'b1, m, pc, pop, 1'b0);
        tick();
        applyStimulus(1'b0, 2'b00, 32'h0, 2'd0, 1'b0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total_checks++;
        assert (observed === expected) pass_checks++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        for (int j = 0; j < 10; j++) exp_q[j] = 32'hbfc00014 + 32'(4 * j);
        exp_q[10] = 32'hbfc00040; exp_q[11] = 32'hbfc00044;
        exp_q[12] = 32'hbfc00048; exp_q[13] = 32'hbfc0004c;

        resetn = 1'b0;
        applyStimulus(1'b0, 2'b00, 32'h0, 2'd0, 1'b0);
        tick(); tick();
        resetn = 1'b1;
        checkOutput("reset_count", 32'(dut.count), 32'd0);
        checkOutput("reset_stall", 32'(iq_stall), 32'd0);
        checkOutput("reset_v1", 32'(out_valid1), 32'd0);
        checkOutput("reset_v2", 32'(out_valid2), 32'd0);

        step(2'b11, 32'hbfc00000, 2'd0);
        checkOutput("t1_v1", 32'(out_valid1), 32'd1);
        checkOutput("t1_v2", 32'(out_valid2), 32'd1);
        checkOutput("t1_pc1", out_pc1, 32'hbfc00000);
        checkOutput("t1_pc2", out_pc2, 32'hbfc00004);
        checkOutput("t1_inst1", out_inst1, ~32'hbfc00000);
        checkOutput("t1_inst2", out_inst2, ~32'hbfc00004);
        for (int k = 1; k < 4; k++) step(2'b11, 32'hbfc00000 + 32'(8 * k), 2'd0);
        checkOutput("t1_count", 32'(dut.count), 32'd8);
        checkOutput("t1_pc1_hold", out_pc1, 32'hbfc00000);

        for (int k = 4; k < 7; k++) step(2'b11, 32'hbfc00000 + 32'(8 * k), 2'd0);
        checkOutput("t2_count14", 32'(dut.count), 32'd14);
        checkOutput("t2_stall14", 32'(iq_stall), 32'd0);
        step(2'b01, 32'hbfc00038, 2'd0);
        checkOutput("t2_count15", 32'(dut.count), 32'd15);
        checkOutput("t2_stall15", 32'(iq_stall), 32'd1);
        applyStimulus(1'b0, 2'b00, 32'h0, 2'd2, 1'b0);
        #1;
        checkOutput("t2_stall_no_pop_path", 32'(iq_stall), 32'd1);
        tick();
        applyStimulus(1'b0, 2'b00, 32'h0, 2'd0, 1'b0);
        checkOutput("t2_count13", 32'(dut.count), 32'd13);
        checkOutput("t2_stall13", 32'(iq_stall), 32'd0);
        checkOutput("t2_pc1", out_pc1, 32'hbfc00008);

        applyStimulus(1'b0, 2'b00, 32'h0, 2'd1, 1'b0);
        tick();
        step(2'b11, 32'hbfc00040, 2'd0);
        checkOutput("t3_count14", 32'(dut.count), 32'd14);
        step(2'b11, 32'hbfc00048, 2'd2);
        checkOutput("t3_count_pushpop", 32'(dut.count), 32'd14);
        checkOutput("t3_stall", 32'(iq_stall), 32'd0);
        for (int i = 0; i < 7; i++) begin
            checkOutput($sformatf("t3_drain%0d_pc1", i), out_pc1, exp_q[2*i]);
            checkOutput($sformatf("t3_drain%0d_pc2", i), out_pc2, exp_q[2*i+1]);
            applyStimulus(1'b0, 2'b00, 32'h0, 2'd2, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 2'b00, 32'h0, 2'd0, 1'b0);
        checkOutput("t3_empty_count", 32'(dut.count), 32'd0);
        checkOutput("t3_empty_v1", 32'(out_valid1), 32'd0);

        step(2'b10, 32'h00000100, 2'd0);
        step(2'b01, 32'h00000108, 2'd0);
        checkOutput("t4_pc1", out_pc1, 32'h00000104);
        checkOutput("t4_pc2", out_pc2, 32'h00000108);
        checkOutput("t4_inst1", out_inst1, ~32'h00000104);
        checkOutput("t4_inst2", out_inst2, ~32'h00000108);
        checkOutput("t4_count", 32'(dut.count), 32'd2);

        step(2'b11, 32'h00000110, 2'd0);
        step(2'b11, 32'h00000118, 2'd0);
        checkOutput("t5_count6", 32'(dut.count), 32'd6);
        applyStimulus(1'b1, 2'b11, 32'h00000120, 2'd2, 1'b1);
        #1;
        checkOutput("t5_flush_v1", 32'(out_valid1), 32'd0);
        checkOutput("t5_flush_v2", 32'(out_valid2), 32'd0);
        tick();
        applyStimulus(1'b0, 2'b00, 32'h0, 2'd0, 1'b0);
        checkOutput("t5_post_count", 32'(dut.count), 32'd0);
        checkOutput("t5_post_v1", 32'(out_valid1), 32'd0);
        step(2'b11, 32'h00000200, 2'd0);
        checkOutput("t5_new_v1", 32'(out_valid1), 32'd1);
        checkOutput("t5_new_pc1", out_pc1, 32'h00000200);

        applyStimulus(1'b0, 2'b00, 32'h0, 2'd1, 1'b0);
        tick();
        applyStimulus(1'b0, 2'b00, 32'h0, 2'd0, 1'b0);
        checkOutput("t6_count1", 32'(dut.count), 32'd1);
        checkOutput("t6_v2_count1", 32'(out_valid2), 32'd0);
        checkOutput("t6_pc1", out_pc1, 32'h00000204);
        applyStimulus(1'b0, 2'b00, 32'h0, 2'd2, 1'b0);
        tick();
        applyStimulus(1'b0, 2'b00, 32'h0, 2'd0, 1'b0);
        checkOutput("t6_clamp_count", 32'(dut.count), 32'd0);
        checkOutput("t6_clamp_head", 32'(dut.head), 32'd2);
        step(2'b11, 32'h00000300, 2'd0);
        applyStimulus(1'b1, 2'b11, 32'h00000308, 2'd1, 1'b1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        applyStimulus(1'b0, 2'b00, 32'h0, 2'd0, 1'b0);
        checkOutput("t6_rst_count", 32'(dut.count), 32'd0);
        checkOutput("t6_rst_head", 32'(dut.head), 32'd0);
        checkOutput("t6_rst_tail", 32'(dut.tail), 32'd0);
        checkOutput("t6_rst_v1", 32'(out_valid1), 32'd0);
        checkOutput("t6_rst_v2", 32'(out_valid2), 32'd0);
        checkOutput("t6_rst_stall", 32'(iq_stall), 32'd0);

        $display("%0d/%0d checks passed", pass_checks, total_checks);
        $finish;
    end

endmodule
